otter_mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter for the OTTER multicycle core. It shares a single variable-latency memory port between the instruction-fetch requester and the load/store requester. Each granted request is latched, driven to memory with a req/ack handshake, and answered with a one-cycle acknowledge pulse on the granted port. A timeout watchdog aborts transactions the memory never acknowledges.

---
 rtl/otter_mem_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_otter_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter
// Shares one variable-latency memory port between the instruction-fetch
// requester (i_*) and the load/store requester (d_*). A granted request is
// latched, presented on m_* until m_ack (or a watchdog timeout), and then
// answered with a one-cycle registered ack pulse on the granted port.
//
// Handshake: i_req/d_req are levels held by the requester until its ack
// pulses; they are sampled only in IDLE. m_req is registered and stays high
// until the cycle in which m_ack is seen high (m_rdata is valid in that same
// cycle); m_ack outside WAIT is ignored.
//
// Build option: define ARB_RR_EN for round-robin arbitration between the two
// ports; without it data always wins over fetch.
module otter_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                RST,
  // fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  // load/store port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  // memory port
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  // debug view of the FSM state (0=IDLE, 1=WAIT, 2=RESP)
  output logic [1:0]          dbg_state
);

  localparam int BE_W  = DATA_W / 8;
  // Counter only needs to reach TIMEOUT_CYC-1.
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_LAST_I = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];
  localparam bit   WDOG_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt_d_q, gnt_d_d;   // 1 = data port owns the transaction
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]     m_be_q, m_be_d;
  logic                i_ack_q, i_ack_d;
  logic                i_err_q, i_err_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic                d_ack_q, d_ack_d;
  logic                d_err_q, d_err_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                pick_d;
  logic                timeout_hit;
  logic [DATA_W-1:0]   resp_data;

`ifdef ARB_RR_EN
  logic                last_d_q, last_d_d;  // last grant went to data port
`endif

  // Arbitration: decide which port wins if a grant happens this cycle.
  always_comb begin
`ifdef ARB_RR_EN
    // Data wins when it is alone, or when both ask and fetch was granted last.
    pick_d = d_req && (!i_req || !last_d_q);
`else
    pick_d = d_req;
`endif
  end

  // Watchdog fires on the last allowed WAIT cycle; m_ack has precedence.
  always_comb begin
    timeout_hit = WDOG_EN && (cnt_q == CNT_LAST);
  end

  // Next-state, latched request fields and response values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d_d   = gnt_d_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    d_rdata_d = d_rdata_q;
    resp_data = '0;
`ifdef ARB_RR_EN
    last_d_d  = last_d_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          gnt_d_d = pick_d;
`ifdef ARB_RR_EN
          last_d_d = pick_d;
`endif
          if (pick_d) begin
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_be_d    = d_be;
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            m_be_d    = '1;
          end
          m_req_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (m_ack || timeout_hit) begin
          // Stores and timed-out accesses return zero data.
          resp_data = (m_ack && !m_we_q) ? m_rdata : '0;
          m_req_d   = 1'b0;
          cnt_d     = '0;
          state_d   = ST_RESP;
          if (gnt_d_q) begin
            d_ack_d   = 1'b1;
            d_err_d   = !m_ack;
            d_rdata_d = resp_data;
          end else begin
            i_ack_d   = 1'b1;
            i_err_d   = !m_ack;
            i_rdata_d = resp_data;
          end
        end else if (WDOG_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        // Ack is visible this cycle; requests are deliberately not sampled.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        m_req_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction at once.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gnt_d_q   <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_d_q   <= gnt_d_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef ARB_RR_EN
  // Last-grant flag; starts as "data" so fetch wins the first contention.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_be      = m_be_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Testbench for otter_mem_arbiter with a small watchdog (TIMEOUT_CYC=4).
// A behavioural memory answers the DUT; a transaction-level model predicts
// the winner, the number of m_req cycles, and the ack/err/data response.
module tb_otter_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  logic          i_req, i_ack, i_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ack, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [BW-1:0] d_be;
  logic          m_req, m_we, m_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [BW-1:0] m_be;
  logic [1:0]    dbg_state;

  otter_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .RST(RST),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata), .dbg_state(dbg_state)
  );

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [DW+1:0] exp_q[$];     // {winner_is_data, err, rdata}
  bit            act_log[$];   // 1 = data port acked
  logic [DW-1:0] mem [logic [AW-1:0]];
`ifdef ARB_RR_EN
  bit last_d = 1'b1;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory contents: unwritten words hold an address-derived pattern
  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic void mem_wr(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input logic [BW-1:0] be);
    logic [DW-1:0] w;
    w = mem_rd(a);
    for (int b = 0; b < BW; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    mem[a] = w;
  endfunction

  // winner predicted from the arbitration rules
  function automatic bit model_pick(input bit ir, input bit dr);
`ifdef ARB_RR_EN
    if (ir && dr) return !last_d;
    return dr;
`else
    if (ir && !dr) return 1'b0;
    return dr;
`endif
  endfunction

  // One transaction. Called at a negedge with the DUT in IDLE and the
  // requests already driven; returns at the negedge of the following IDLE.
  // lat = WAIT cycles before the memory acks (>= TO means never in time).
  task automatic run_txn(input int lat, input bit withdraw, input bit drop_at_resp);
    bit            win_d, tmo;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew, ed;
    logic [BW-1:0] ebe;
    logic          ewe;
    logic [DW+1:0] exp_v, got_v;
    int            k, nreq, spur;
    win_d = model_pick(i_req, d_req);
`ifdef ARB_RR_EN
    last_d = win_d;
`endif
    if (win_d) begin
      ea = d_addr; ewe = d_we; ew = d_wdata; ebe = d_be;
    end else begin
      ea = i_addr; ewe = 1'b0; ew = '0; ebe = '1;
    end
    tmo = (lat >= TO);
    ed  = (tmo || ewe) ? '0 : mem_rd(ea);
    exp_q.push_back({win_d, tmo, ed});

    @(negedge clk);
    check_eq("m_req_rise", m_req, 1);
    check_eq("m_addr", m_addr, ea);
    check_eq("m_we", m_we, ewe);
    check_eq("m_wdata", m_wdata, ew);
    check_eq("m_be", m_be, ebe);
    if (withdraw) begin
      i_req = 1'b0; d_req = 1'b0;
      i_addr = $urandom; d_addr = $urandom; d_we = $urandom_range(0, 1);
    end

    k = 0; nreq = 0; spur = 0;
    while (m_req === 1'b1 && k < 64) begin
      nreq++;
      if (i_ack || d_ack) spur++;
      if (k == lat) begin
        m_ack = 1'b1;
        m_rdata = mem_rd(m_addr);
        if (m_we) mem_wr(m_addr, m_wdata, m_be);
      end else begin
        m_ack = 1'b0;
        m_rdata = $urandom;
      end
      @(negedge clk);
      k++;
    end
    m_ack = 1'b0;
    m_rdata = $urandom;

    check_eq("m_req_cycles", nreq, tmo ? TO : lat + 1);
    check_eq("early_ack", spur, 0);
    exp_v = exp_q.pop_front();
    check_eq("ack_port", {i_ack, d_ack}, exp_v[DW+1] ? 2'b01 : 2'b10);
    got_v = exp_v[DW+1] ? {1'b1, d_err, d_rdata} : {1'b0, i_err, i_rdata};
    check_eq("resp", got_v, exp_v);
    check_eq("err_other", exp_v[DW+1] ? i_err : d_err, 0);
    act_log.push_back(d_ack);
    if (drop_at_resp) begin
      i_req = 1'b0; d_req = 1'b0;
    end
    @(negedge clk);
    check_eq("ack_one_cycle", {i_ack, d_ack, i_err, d_err}, 0);
    check_eq("m_req_idle", m_req, 0);
  endtask

  task automatic set_fetch(input logic [AW-1:0] a);
    i_req = 1'b1; i_addr = a;
  endtask

  task automatic set_data(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [BW-1:0] be);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
  endtask

  // global bound so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit held_exp[4];
    int ra_seen;
    RST = 1'b1;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    m_ack = 0; m_rdata = '0;
    repeat (3) @(negedge clk);

    // reset values
    check_eq("rst_acks", {i_ack, i_err, d_ack, d_err, m_req, m_we}, 0);
    check_eq("rst_m_addr", m_addr, 0);
    check_eq("rst_m_wdata", m_wdata, 0);
    check_eq("rst_m_be", m_be, 0);
    check_eq("rst_i_rdata", i_rdata, 0);
    check_eq("rst_d_rdata", d_rdata, 0);
    RST = 1'b0;
    @(negedge clk);

    // both ports held for four transactions
    set_fetch(32'h104);
    set_data(1'b0, 32'h3000, 32'h0, 4'hF);
    act_log.delete();
    for (int t = 0; t < 4; t++) run_txn(t % 2, 1'b0, t == 3);
`ifdef ARB_RR_EN
    held_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    held_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int t = 0; t < 4; t++) check_eq($sformatf("held_order%0d", t), act_log[t], held_exp[t]);

    // fetch, zero-wait memory
    mem[32'h100] = 32'h0050_0093;
    set_fetch(32'h100);
    run_txn(0, 1'b0, 1'b1);

    // store with three wait cycles, then read it back
    set_data(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF);
    run_txn(3, 1'b0, 1'b1);
    set_data(1'b0, 32'h2000, 32'h0, 4'hF);
    run_txn(1, 1'b0, 1'b1);

    // partial-byte store then load
    set_data(1'b1, 32'h2000, 32'h1122_3344, 4'b0101);
    run_txn(0, 1'b0, 1'b1);
    set_fetch(32'h2000);
    run_txn(2, 1'b0, 1'b1);

    // memory never answers: watchdog abort on a load
    set_data(1'b0, 32'h30, 32'h0, 4'hF);
    run_txn(1000, 1'b0, 1'b1);

    // m_ack on the final timeout cycle wins
    set_data(1'b0, 32'h34, 32'h0, 4'hF);
    run_txn(TO - 1, 1'b0, 1'b1);

    // requester withdraws during WAIT; transaction still completes
    set_fetch(32'h200);
    run_txn(2, 1'b1, 1'b1);

    // reset mid-transaction
    set_fetch(32'h400);
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_m_req", m_req, 1);
    #2 RST = 1'b1;
    #1 check_eq("rst_async_m_req", m_req, 0);
    i_req = 1'b0;
`ifdef ARB_RR_EN
    last_d = 1'b1;
`endif
    ra_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (i_ack || d_ack || m_req) ra_seen++;
    end
    check_eq("rst_no_ack", ra_seen, 0);
    RST = 1'b0;
    @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    m_ack = 1'b0;
    check_eq("stray_m_req", m_req, 0);
    @(negedge clk);
    check_eq("stray_acks", {i_ack, d_ack, i_err, d_err}, 0);
    check_eq("stray_rdata", {i_rdata, d_rdata}, 0);
    set_fetch(32'h100);
    run_txn(1, 1'b0, 1'b1);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      bit ui, ud;
      ui = $urandom_range(0, 1);
      ud = $urandom_range(0, 1);
      if (!ui && !ud) ud = 1'b1;
      if (ui) set_fetch({26'h0, 4'($urandom_range(0, 15)), 2'b00});
      if (ud) set_data($urandom_range(0, 1), {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                       $urandom, 4'($urandom_range(1, 15)));
      run_txn($urandom_range(0, TO + 1), $urandom_range(0, 3) == 0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
